// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request-response handshake with a fixed access latency.
// Optional address error check is compiled in with `define DMEM_ADDR_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for a request; req_ready high
// BUSY   | request captured, counting down the access latency
// RESP   | response held on resp_* until resp_ready
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..7");
  end

  if (DEPTH_WORDS < 16 || DEPTH_WORDS > 4096 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("data_mem_responder: DEPTH_WORDS must be a power of two in 16..4096");
  end

  logic [1:0]       r_state;
  logic [2:0]       r_cnt;
  logic             r_write;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic             r_bad;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic             w_addr_bad;

`ifdef DMEM_ADDR_CHECK_EN
  assign w_addr_bad = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(4 * DEPTH_WORDS));
`else
  // Without the check, the byte offset and high address bits simply wrap away.
  logic w_unused_addr;
  assign w_unused_addr = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
  assign w_addr_bad    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_bad   <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_idx   <= req_addr[IDX_W+1:2];
            r_wdata <= req_wdata;
            r_bad   <= w_addr_bad;
            r_cnt   <= LAT_M1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == 3'd0) begin
            r_state <= S_RESP;
            // Flagged requests still take the full latency but never touch the array.
            if (r_bad) begin
              r_rdata <= 32'd0;
              r_err   <= 1'b1;
            end else begin
              r_err <= 1'b0;
              if (r_write) begin
                r_mem[r_idx] <= r_wdata;
                r_rdata      <= 32'd0;
              end else begin
                r_rdata <= r_mem[r_idx];
              end
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE) && !reset;
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (LATENCY 2, 1, 7) share clock, reset and request payload.
// Address-check expectations follow `define DMEM_ADDR_CHECK_EN.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(7)) dut_l7 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on instance k; hold = cycles of resp_ready=0 after resp_valid rises.
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input int hold, input bit keep_valid, input int exp_lat,
                     input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int lat;
    chk({tag, "/req_ready_idle"}, 32'(req_ready[k]), 32'd1);
    req_write     = w;
    req_addr      = a;
    req_wdata     = d;
    req_valid[k]  = 1'b1;
    resp_ready[k] = (hold == 0);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      if (!keep_valid) req_valid[k] = 1'b0;
      req_addr  = ~a;
      req_wdata = ~d;
      req_write = ~w;
      if (resp_valid[k]) break;
      chk({tag, "/req_ready_busy"}, 32'(req_ready[k]), 32'd0);
      @(posedge clk);
      lat++;
    end while (lat < 20);
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/rdata"}, resp_rdata[k], exp_rdata);
    chk({tag, "/err"}, 32'(resp_err[k]), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "/hold_valid"}, 32'(resp_valid[k]), 32'd1);
      chk({tag, "/hold_rdata"}, resp_rdata[k], exp_rdata);
      chk({tag, "/hold_req_ready"}, 32'(req_ready[k]), 32'd0);
    end
    resp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "/valid_after"}, 32'(resp_valid[k]), 32'd0);
    chk({tag, "/req_ready_after"}, 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k]  = 1'b0;
      resp_ready[k] = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst/req_ready", 32'(req_ready[0]), 32'd0);
    chk("rst/resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst/resp_rdata", resp_rdata[0], 32'd0);
    chk("rst/resp_err", 32'(resp_err[0]), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst/req_ready_release", 32'(req_ready[0]), 32'd1);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 2, 32'h0, 1'b0, "st10");
    txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 2, 32'hDEADBEEF, 1'b0, "ld10");

    txn(0, 1'b1, 32'h20, 32'h12345678, 0, 1'b0, 2, 32'h0, 1'b0, "st20");
    txn(0, 1'b0, 32'h20, 32'h0, 5, 1'b0, 2, 32'h12345678, 1'b0, "ld20_bp");

    txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b1, 2, 32'hDEADBEEF, 1'b0, "ld10_hold_valid");

    txn(1, 1'b1, 32'h30, 32'h11111111, 0, 1'b0, 1, 32'h0, 1'b0, "l1_st30");
    txn(1, 1'b0, 32'h30, 32'h0, 0, 1'b1, 1, 32'h11111111, 1'b0, "l1_ld30");
    txn(2, 1'b1, 32'h34, 32'h77777777, 0, 1'b0, 7, 32'h0, 1'b0, "l7_st34");
    txn(2, 1'b0, 32'h34, 32'h0, 0, 1'b1, 7, 32'h77777777, 1'b0, "l7_ld34");

`ifdef DMEM_ADDR_CHECK_EN
    txn(0, 1'b1, 32'h402, 32'hCAFEF00D, 0, 1'b0, 2, 32'h0, 1'b1, "chk_st402");
    txn(0, 1'b1, 32'h400, 32'hCAFEF00D, 0, 1'b0, 2, 32'h0, 1'b1, "chk_st400");
    txn(0, 1'b0, 32'h000, 32'h0, 0, 1'b0, 2, 32'h0, 1'b0, "chk_ld000");
    txn(0, 1'b0, 32'h012, 32'h0, 0, 1'b0, 2, 32'h0, 1'b1, "chk_ld012");
    txn(0, 1'b0, 32'h010, 32'h0, 0, 1'b0, 2, 32'hDEADBEEF, 1'b0, "chk_ld010");
`else
    txn(0, 1'b1, 32'h404, 32'h0BADF00D, 0, 1'b0, 2, 32'h0, 1'b0, "wrap_st404");
    txn(0, 1'b0, 32'h004, 32'h0, 0, 1'b0, 2, 32'h0BADF00D, 1'b0, "wrap_ld004");
    txn(0, 1'b0, 32'h006, 32'h0, 0, 1'b0, 2, 32'h0BADF00D, 1'b0, "wrap_ld006");
    txn(0, 1'b0, 32'h000, 32'h0, 0, 1'b0, 2, 32'h0, 1'b0, "wrap_ld000");
`endif

    // Store to 0x8 interrupted by reset while BUSY.
    req_write    = 1'b1;
    req_addr     = 32'h8;
    req_wdata    = 32'hA5A5A5A5;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("midrst/busy_req_ready", 32'(req_ready[0]), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("midrst/resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("midrst/resp_rdata", resp_rdata[0], 32'd0);
    chk("midrst/resp_err", 32'(resp_err[0]), 32'd0);
    chk("midrst/req_ready", 32'(req_ready[0]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst/req_ready_release", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 32'h8, 32'h0, 0, 1'b0, 2, 32'h0, 1'b0, "midrst_ld8");
    txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 2, 32'h0, 1'b0, "midrst_ld10");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
